muldiv_sequencer: RTL

Multi-cycle multiply/divide sequencer and HI/LO register owner for the EX stage. It accepts one long-latency operation at a time (MULT, MULTU, DIV, DIVU, MUL) or a HI/LO move (MTHI, MTLO). It runs the operation to completion, using an internal MUL_LAT-stage multiplier timer and a 32-iteration restoring divider, and stalls the pipeline while busy. It commits HI/LO only if the instruction is not flushed by a later-stage exception.

---
 rtl/muldiv_sequencer_if.sv | 23 ++
 rtl/muldiv_sequencer.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide sequencer.
interface muldiv_sequencer_if;
  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output op_valid, op, a, b, flush,
    input  stall, done, result, hi, lo
  );

  modport slave (
    input  op_valid, op, a, b, flush,
    output stall, done, result, hi, lo
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Multiplies wait MUL_LAT cycles on a '*' product; divides run a 32-step restoring loop.
module muldiv_sequencer #(
  parameter int unsigned MUL_LAT = 2
) (
  input logic               clk,
  input logic               rst,
  muldiv_sequencer_if.slave bus
);
  localparam logic [2:0] OpMult = 3'd0;
  localparam logic [2:0] OpDiv  = 3'd2;
  localparam logic [2:0] OpDivu = 3'd3;
  localparam logic [2:0] OpMthi = 3'd4;
  localparam logic [2:0] OpMtlo = 3'd5;
  localparam logic [2:0] OpMul  = 3'd6;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  state_e      state_q, state_d;
  logic [2:0]  op_q, op_d;
  logic [31:0] ma_q, ma_d;   // multiplicand magnitude, reused as dividend/quotient shifter
  logic [31:0] mb_q, mb_d;
  logic [31:0] rem_q, rem_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        psign_q, psign_d;
  logic        rsign_q, rsign_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] hi_next_q, hi_next_d, lo_next_q, lo_next_d;

  logic        long_op, div_op, signed_op;
  logic [31:0] a_mag, b_mag;
  logic [63:0] prod_mag, prod;
  logic [32:0] rem_sh, diff;
  logic        qbit;
  logic [31:0] rem_step, quo_step;

  always_comb begin
    long_op   = (bus.op <= OpDivu) || (bus.op == OpMul);
    div_op    = (bus.op == OpDiv) || (bus.op == OpDivu);
    signed_op = (bus.op == OpMult) || (bus.op == OpDiv);
    a_mag     = (signed_op && bus.a[31]) ? -bus.a : bus.a;
    b_mag     = (signed_op && bus.b[31]) ? -bus.b : bus.b;
    prod_mag  = 64'(ma_q) * 64'(mb_q);
    prod      = psign_q ? -prod_mag : prod_mag;
    // Remainder never exceeds the divisor, so 32 stored bits plus the shifted-in bit suffice.
    rem_sh    = {rem_q, ma_q[31]};
    diff      = rem_sh - {1'b0, mb_q};
    qbit      = ~diff[32];
    rem_step  = qbit ? diff[31:0] : rem_sh[31:0];
    quo_step  = {ma_q[30:0], qbit};
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    psign_d   = psign_q;
    rsign_d   = rsign_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    hi_next_d = hi_next_q;
    lo_next_d = lo_next_q;
    unique case (state_q)
      StIdle: begin
        if (bus.op_valid && !bus.flush) begin
          if (long_op) begin
            state_d = div_op ? StDiv : StMul;
            op_d    = bus.op;
            ma_d    = a_mag;
            mb_d    = b_mag;
            rem_d   = '0;
            cnt_d   = '0;
            psign_d = signed_op & (bus.a[31] ^ bus.b[31]);
            rsign_d = signed_op & bus.a[31];
          end else if (bus.op == OpMthi) begin
            hi_d = bus.a;
          end else if (bus.op == OpMtlo) begin
            lo_d = bus.a;
          end
        end
      end
      StMul: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (cnt_q == 5'(MUL_LAT - 1)) begin
          {hi_next_d, lo_next_d} = prod;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      StDiv: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (mb_q == '0) begin
          // Divide by zero leaves HI/LO as they are; the trap is raised elsewhere.
          hi_next_d = hi_q;
          lo_next_d = lo_q;
          state_d   = StDone;
        end else begin
          ma_d  = quo_step;
          rem_d = rem_step;
          if (cnt_q == 5'd31) begin
            hi_next_d = rsign_q ? -rem_step : rem_step;
            lo_next_d = psign_q ? -quo_step : quo_step;
            state_d   = StDone;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StDone: begin
        if (!bus.flush && op_q != OpMul) begin
          hi_d = hi_next_q;
          lo_d = lo_next_q;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      op_q      <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      rem_q     <= '0;
      cnt_q     <= '0;
      psign_q   <= 1'b0;
      rsign_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      hi_next_q <= '0;
      lo_next_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      psign_q   <= psign_d;
      rsign_q   <= rsign_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      hi_next_q <= hi_next_d;
      lo_next_q <= lo_next_d;
    end
  end

  always_comb begin
    bus.stall  = (state_q == StIdle && bus.op_valid && long_op && !bus.flush) ||
                 (state_q == StMul) || (state_q == StDiv);
    bus.done   = (state_q == StDone);
    bus.result = (state_q == StDone && op_q == OpMul) ? lo_next_q : '0;
    bus.hi     = hi_q;
    bus.lo     = lo_q;
  end
endmodule
